// File: rtl/keypad_write_ctrl_if.sv
// Register-bank write port plus key status seen by the bank side.
interface keypad_write_ctrl_if;
    logic [3:0] addrW;
    logic [3:0] datW;
    logic       RegWrite;
    logic       key_valid;
    logic [3:0] key_code;
    logic       phase;

    modport master (
        output addrW, datW, RegWrite, key_valid, key_code, phase
    );

    modport slave (
        input addrW, datW, RegWrite, key_valid, key_code, phase
    );
endinterface

// File: rtl/keypad_write_ctrl.sv
// 4x4 keypad scanner with debounce; address key then data key
// produce a one-cycle write into the register bank.
module keypad_write_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          row_in,
    output logic [3:0]          col_out,
    keypad_write_ctrl_if.master bank
);
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {ADDR, DATA, WRITE} state_t;

    logic [3:0]    row_s1;
    logic [3:0]    row_s;
    logic [DW-1:0] div;
    logic [1:0]    col;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;
    logic          cand_key;
    logic [3:0]    cand_code;
    logic [SW-1:0] stab;
    logic          reported;
    state_t        state;
    logic [3:0]    addr_r;

    logic [2:0]    col_hits;
    logic [3:0]    col_code;
    logic [2:0]    sum;
    logic [1:0]    new_cnt;
    logic          res_key;
    logic          same;
    logic [SW-1:0] nxt_stab;

    assign col_out = ~(4'b0001 << col);

    always_comb begin
        col_hits = 3'd0;
        col_code = acc_code;
        for (int r = 0; r < 4; r++) begin
            if (!row_s[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = {2'(r), col};
            end
        end
        sum      = {1'b0, acc_cnt} + col_hits;
        new_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        res_key  = (new_cnt == 2'd1);
        same     = (res_key == cand_key) &&
                   (!res_key || col_code == cand_code);
        nxt_stab = 1;
        if (same)
            nxt_stab = (stab == STAB_MAX) ? stab : stab + SW'(1);
    end

    // Two-flop synchronizer, column scanner, accumulator and debounce
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_s1         <= 4'hf;
            row_s          <= 4'hf;
            div            <= '0;
            col            <= 2'd0;
            acc_cnt        <= 2'd0;
            acc_code       <= 4'd0;
            cand_key       <= 1'b0;
            cand_code      <= 4'd0;
            stab           <= '0;
            reported       <= 1'b0;
            bank.key_valid <= 1'b0;
            bank.key_code  <= 4'd0;
        end else begin
            row_s1         <= row_in;
            row_s          <= row_s1;
            bank.key_valid <= 1'b0;
            if (div == DIV_MAX) begin
                div <= '0;
                col <= col + 2'd1;
                if (col == 2'd3) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= 4'd0;
                    cand_key <= res_key;
                    if (res_key)
                        cand_code <= col_code;
                    stab <= nxt_stab;
                    if (nxt_stab == STAB_MAX) begin
                        if (res_key && !reported) begin
                            bank.key_valid <= 1'b1;
                            bank.key_code  <= col_code;
                            reported       <= 1'b1;
                        end else if (!res_key) begin
                            reported <= 1'b0;
                        end
                    end
                end else begin
                    acc_cnt  <= new_cnt;
                    acc_code <= col_code;
                end
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    // Write outputs load on the DATA->WRITE edge so they are valid
    // together with RegWrite during the WRITE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ADDR;
            addr_r        <= 4'd0;
            bank.addrW    <= 4'd0;
            bank.datW     <= 4'd0;
            bank.RegWrite <= 1'b0;
            bank.phase    <= 1'b0;
        end else begin
            bank.RegWrite <= 1'b0;
            unique case (state)
                ADDR: begin
                    if (bank.key_valid) begin
                        addr_r     <= bank.key_code;
                        bank.phase <= 1'b1;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (bank.key_valid) begin
                        bank.addrW    <= addr_r;
                        bank.datW     <= bank.key_code;
                        bank.RegWrite <= 1'b1;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    bank.phase <= 1'b0;
                    state      <= ADDR;
                end
                default: begin
                    bank.phase <= 1'b0;
                    state      <= ADDR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_write_ctrl.sv
// Directed bench: keypad matrix model driving keypad_write_ctrl
// with SCAN_DIV=4, DEBOUNCE_SCANS=2 (one scan = 16 clks).
module tb_keypad_write_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] keys = 16'h0;

    keypad_write_ctrl_if bus ();

    keypad_write_ctrl #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row_in(row_in),
        .col_out(col_out),
        .bank(bus.master)
    );

    always #5 clk = ~clk;

    // Key (r,c) at index 4*r+c pulls row r low while column c is driven
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !col_out[c])
                    row_in[r] = 1'b0;
        end
    end

    int total = 0;
    int bad = 0;
    int kv_cnt = 0;
    int rw_cnt = 0;
    int rw_bad9 = 0;
    logic [3:0] rw_addr = 4'd0;
    logic [3:0] rw_dat = 4'd0;
    logic [3:0] kv_log[$];

    always @(negedge clk) begin
        if (bus.key_valid === 1'b1) begin
            kv_cnt++;
            kv_log.push_back(bus.key_code);
        end
        if (bus.RegWrite === 1'b1) begin
            rw_cnt++;
            rw_addr = bus.addrW;
            rw_dat = bus.datW;
            if (bus.addrW == 4'd9)
                rw_bad9++;
        end
    end

    task automatic scans(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    task automatic press(input int code, input int n);
        keys = 16'h0;
        keys[code] = 1'b1;
        scans(n);
    endtask

    task automatic release_all(input int n);
        keys = 16'h0;
        scans(n);
    endtask

    task automatic test_reset;
        logic [3:0] exp;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (col_out !== 4'b1110) begin
            bad++;
            $display("FAIL reset_col got=%b exp=1110", col_out);
        end
        total++;
        if (bus.addrW !== 4'd0 || bus.datW !== 4'd0) begin
            bad++;
            $display("FAIL reset_bus got=%h/%h exp=0/0",
                     bus.addrW, bus.datW);
        end
        total++;
        if (bus.RegWrite !== 1'b0 || bus.key_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b%b exp=00",
                     bus.RegWrite, bus.key_valid);
        end
        total++;
        if (bus.phase !== 1'b0 || bus.key_code !== 4'd0) begin
            bad++;
            $display("FAIL reset_phase got=%b/%h exp=0/0",
                     bus.phase, bus.key_code);
        end
        rst = 1'b1;
        for (int j = 0; j < 20; j++) begin
            exp = ~(4'b0001 << ((j / 4) % 4));
            total++;
            if (col_out !== exp) begin
                bad++;
                $display("FAIL scan_col cyc=%0d got=%b exp=%b",
                         j, col_out, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write;
        int kv0 = kv_cnt;
        int rw0 = rw_cnt;
        int q0 = kv_log.size();
        press(6, 3);
        release_all(3);
        total++;
        if (kv_cnt != kv0 + 1 || kv_log.size() <= q0 ||
            kv_log[q0] !== 4'd6) begin
            bad++;
            $display("FAIL addr_key cnt=%0d exp=%0d", kv_cnt - kv0, 1);
        end
        total++;
        if (bus.phase !== 1'b1) begin
            bad++;
            $display("FAIL phase_data got=%b exp=1", bus.phase);
        end
        total++;
        if (rw_cnt != rw0) begin
            bad++;
            $display("FAIL early_write got=%0d exp=0", rw_cnt - rw0);
        end
        press(3, 3);
        release_all(3);
        total++;
        if (kv_cnt != kv0 + 2 || kv_log.size() <= q0 + 1 ||
            kv_log[q0+1] !== 4'd3) begin
            bad++;
            $display("FAIL data_key cnt=%0d exp=2", kv_cnt - kv0);
        end
        total++;
        if (rw_cnt != rw0 + 1) begin
            bad++;
            $display("FAIL write_cnt got=%0d exp=1", rw_cnt - rw0);
        end
        total++;
        if (rw_addr !== 4'd6 || rw_dat !== 4'd3) begin
            bad++;
            $display("FAIL write_val got=%h/%h exp=6/3", rw_addr, rw_dat);
        end
        total++;
        if (bus.addrW !== 4'd6 || bus.datW !== 4'd3 ||
            bus.RegWrite !== 1'b0 || bus.phase !== 1'b0) begin
            bad++;
            $display("FAIL write_hold got=%h/%h/%b/%b exp=6/3/0/0",
                     bus.addrW, bus.datW, bus.RegWrite, bus.phase);
        end
    endtask

    task automatic test_bounce;
        int kv0 = kv_cnt;
        for (int i = 0; i < 3; i++) begin
            press(9, 1);
            release_all(1);
        end
        release_all(3);
        total++;
        if (kv_cnt != kv0) begin
            bad++;
            $display("FAIL bounce_kv got=%0d exp=0", kv_cnt - kv0);
        end
        total++;
        if (bus.phase !== 1'b0) begin
            bad++;
            $display("FAIL bounce_phase got=%b exp=0", bus.phase);
        end
    endtask

    task automatic test_hold_ghost;
        int kv0 = kv_cnt;
        int rw0 = rw_cnt;
        int q0 = kv_log.size();
        press(15, 20);
        release_all(3);
        total++;
        if (kv_cnt != kv0 + 1 || kv_log.size() <= q0 ||
            kv_log[q0] !== 4'd15) begin
            bad++;
            $display("FAIL long_hold cnt=%0d exp=1", kv_cnt - kv0);
        end
        keys = 16'h0;
        keys[0] = 1'b1;
        keys[9] = 1'b1;
        scans(6);
        release_all(3);
        total++;
        if (kv_cnt != kv0 + 1) begin
            bad++;
            $display("FAIL ghost cnt=%0d exp=1", kv_cnt - kv0);
        end
        total++;
        if (bus.phase !== 1'b1) begin
            bad++;
            $display("FAIL ghost_phase got=%b exp=1", bus.phase);
        end
        press(0, 3);
        release_all(3);
        total++;
        if (rw_cnt != rw0 + 1 || rw_addr !== 4'd15 || rw_dat !== 4'd0) begin
            bad++;
            $display("FAIL edge_write cnt=%0d got=%h/%h exp=1 f/0",
                     rw_cnt - rw0, rw_addr, rw_dat);
        end
    endtask

    task automatic test_reset_mid;
        int rw0 = rw_cnt;
        press(9, 3);
        release_all(3);
        total++;
        if (bus.phase !== 1'b1) begin
            bad++;
            $display("FAIL mid_phase got=%b exp=1", bus.phase);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++;
        if (bus.phase !== 1'b0 || bus.addrW !== 4'd0 ||
            bus.datW !== 4'd0 || col_out !== 4'b1110) begin
            bad++;
            $display("FAIL mid_reset got=%b/%h/%h/%b exp=0/0/0/1110",
                     bus.phase, bus.addrW, bus.datW, col_out);
        end
        press(2, 3);
        release_all(3);
        press(5, 3);
        release_all(3);
        total++;
        if (rw_cnt != rw0 + 1) begin
            bad++;
            $display("FAIL mid_write_cnt got=%0d exp=1", rw_cnt - rw0);
        end
        total++;
        if (rw_addr !== 4'd2 || rw_dat !== 4'd5) begin
            bad++;
            $display("FAIL mid_write got=%h/%h exp=2/5", rw_addr, rw_dat);
        end
        total++;
        if (rw_bad9 != 0) begin
            bad++;
            $display("FAIL addr9_write got=%0d exp=0", rw_bad9);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bounce();
        test_hold_ghost();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
